// File: rtl/vga_rect_fill_if.sv
// Pixel-fill request and adapter write-port bundle between draw logic and vga_rect_fill_ctrl.
`timescale 1ns/1ps
interface vga_rect_fill_if #(
    parameter int COLOUR_BITS = 3
);
    logic                   start;
    logic [7:0]             x0;
    logic [6:0]             y0;
    logic [7:0]             w;
    logic [6:0]             h;
    logic [COLOUR_BITS-1:0] colour_in;
    logic                   hold;
    logic [7:0]             x;
    logic [6:0]             y;
    logic [COLOUR_BITS-1:0] colour;
    logic                   plot;
    logic                   busy;
    logic                   done;

    modport master (
        output start, x0, y0, w, h, colour_in, hold,
        input  x, y, colour, plot, busy, done
    );

    modport slave (
        input  start, x0, y0, w, h, colour_in, hold,
        output x, y, colour, plot, busy, done
    );
endinterface

// File: rtl/vga_rect_fill_ctrl.sv
// Walks a clipped rectangle in raster order, presenting one pixel write per cycle
// to the vga_adapter write port, with hold back-pressure and busy/done status.
`timescale 1ns/1ps
module vga_rect_fill_ctrl #(
    parameter int SCREEN_W    = 160,
    parameter int SCREEN_H    = 120,
    parameter int COLOUR_BITS = 3
) (
    input  logic           clock,
    input  logic           reset,
    vga_rect_fill_if.slave bus
);
    typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

    localparam logic [8:0] X_MAX = 9'(SCREEN_W - 1);
    localparam logic [7:0] Y_MAX = 8'(SCREEN_H - 1);

    state_t                 state, state_n;
    logic [7:0]             x_r, x_n, x_start, x_start_n, x_end, x_end_n;
    logic [6:0]             y_r, y_n, y_end, y_end_n;
    logic [COLOUR_BITS-1:0] colour_r, colour_n;
    logic                   plot_r, plot_n, busy_r, busy_n, done_r, done_n;
    logic [8:0]             x_sum;
    logic [7:0]             y_sum;
    logic                   degenerate;

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            x_r      <= '0;
            y_r      <= '0;
            colour_r <= '0;
            plot_r   <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            state    <= state_n;
            x_r      <= x_n;
            y_r      <= y_n;
            colour_r <= colour_n;
            plot_r   <= plot_n;
            busy_r   <= busy_n;
            done_r   <= done_n;
        end
        x_start <= x_start_n;
        x_end   <= x_end_n;
        y_end   <= y_end_n;
    end

    always_comb begin
        state_n    = state;
        x_n        = x_r;
        y_n        = y_r;
        colour_n   = colour_r;
        x_start_n  = x_start;
        x_end_n    = x_end;
        y_end_n    = y_end;
        plot_n     = 1'b0;
        busy_n     = busy_r;
        done_n     = 1'b0;
        // Widened sums so an oversized rectangle clips instead of wrapping
        x_sum      = {1'b0, bus.x0} + {1'b0, bus.w} - 9'd1;
        y_sum      = {1'b0, bus.y0} + {1'b0, bus.h} - 8'd1;
        degenerate = (bus.w == 8'd0) || (bus.h == 7'd0) ||
                     ({1'b0, bus.x0} > X_MAX) || ({1'b0, bus.y0} > Y_MAX);

        case (state)
            IDLE: begin
                if (bus.start) begin
                    if (degenerate) begin
                        state_n = DONE;
                        done_n  = 1'b1;
                    end else begin
                        state_n   = FILL;
                        x_n       = bus.x0;
                        y_n       = bus.y0;
                        colour_n  = bus.colour_in;
                        x_start_n = bus.x0;
                        x_end_n   = (x_sum > X_MAX) ? X_MAX[7:0] : x_sum[7:0];
                        y_end_n   = (y_sum > Y_MAX) ? Y_MAX[6:0] : y_sum[6:0];
                        plot_n    = !bus.hold;
                        busy_n    = 1'b1;
                    end
                end
            end
            FILL: begin
                // A pixel is consumed only in a cycle where it was presented with plot high;
                // a held cycle re-presents the same coordinates once hold drops.
                if (plot_r) begin
                    if (x_r == x_end && y_r == y_end) begin
                        state_n = DONE;
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                    end else begin
                        if (x_r < x_end) begin
                            x_n = x_r + 8'd1;
                        end else begin
                            x_n = x_start;
                            y_n = y_r + 7'd1;
                        end
                        plot_n = !bus.hold;
                    end
                end else begin
                    plot_n = !bus.hold;
                end
            end
            DONE: begin
                state_n = IDLE;
                busy_n  = 1'b0;
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.x      = x_r;
    assign bus.y      = y_r;
    assign bus.colour = colour_r;
    assign bus.plot   = plot_r;
    assign bus.busy   = busy_r;
    assign bus.done   = done_r;
endmodule

// File: tb/tb_vga_rect_fill_ctrl.sv
// Directed bench for vga_rect_fill_ctrl: table of rectangles plus hold, overlap and reset sequences.
`timescale 1ns/1ps
module tb_vga_rect_fill_ctrl;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    vga_rect_fill_if #(.COLOUR_BITS(3)) bus();

    vga_rect_fill_ctrl #(.SCREEN_W(160), .SCREEN_H(120), .COLOUR_BITS(3)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [7:0] x0;
        logic [6:0] y0;
        logic [7:0] w;
        logic [6:0] h;
        logic [2:0] col;
        int         exp_n;
        logic [7:0] xe;
        logic [6:0] ye;
    } vec_t;

    typedef struct {
        logic [7:0] x;
        logic [6:0] y;
        logic       plot;
        logic       done;
    } obs_t;

    vec_t vecs[8];
    obs_t hold_exp[10];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_req(input logic [7:0] x0, input logic [6:0] y0,
                           input logic [7:0] w, input logic [6:0] h, input logic [2:0] col);
        bus.x0 = x0; bus.y0 = y0; bus.w = w; bus.h = h; bus.colour_in = col;
    endtask

    // Issues one request and follows it until the done pulse, checking the raster walk.
    task automatic run_vec(input string nm, input vec_t v);
        int   n = 0, bad = 0, oob = 0, busy_bad = 0, first_cyc = -1, seen_done = 0;
        logic [7:0] ex = v.x0;
        logic [6:0] ey = v.y0;
        set_req(v.x0, v.y0, v.w, v.h, v.col);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int cyc = 0; cyc < 20010 && seen_done == 0; cyc++) begin
            if (bus.plot) begin
                if (first_cyc < 0) first_cyc = cyc;
                if (bus.x !== ex || bus.y !== ey || bus.colour !== v.col) bad++;
                if (int'(bus.x) > 159 || int'(bus.y) > 119) oob++;
                if (!bus.busy) busy_bad++;
                n++;
                if (ex == v.xe) begin ex = v.x0; ey++; end
                else ex++;
            end
            if (v.exp_n == 0 && bus.busy) busy_bad++;
            if (bus.done) begin
                seen_done = 1;
                if (bus.busy || bus.plot) busy_bad++;
            end else begin
                step();
            end
        end
        chk({nm, " done_seen"}, seen_done, 1);
        chk({nm, " plots"}, n, v.exp_n);
        chk({nm, " order_errs"}, bad, 0);
        chk({nm, " off_screen"}, oob, 0);
        chk({nm, " busy_errs"}, busy_bad, 0);
        if (v.exp_n > 0) chk({nm, " first_latency"}, first_cyc, 0);
        step();
        chk({nm, " done_one_cycle"}, int'(bus.done), 0);
    endtask

    initial begin
        int n, dones, badcol;

        vecs[0] = '{8'd10,  7'd5,   8'd3,   7'd2,   3'd5, 6,     8'd12,  7'd6};
        vecs[1] = '{8'd0,   7'd0,   8'd160, 7'd120, 3'd2, 19200, 8'd159, 7'd119};
        vecs[2] = '{8'd158, 7'd119, 8'd5,   7'd4,   3'd7, 2,     8'd159, 7'd119};
        vecs[3] = '{8'd20,  7'd20,  8'd0,   7'd4,   3'd1, 0,     8'd0,   7'd0};
        vecs[4] = '{8'd200, 7'd10,  8'd4,   7'd4,   3'd1, 0,     8'd0,   7'd0};
        vecs[5] = '{8'd5,   7'd5,   8'd4,   7'd0,   3'd3, 0,     8'd0,   7'd0};
        vecs[6] = '{8'd5,   7'd125, 8'd4,   7'd4,   3'd3, 0,     8'd0,   7'd0};
        vecs[7] = '{8'd0,   7'd0,   8'd1,   7'd1,   3'd6, 1,     8'd0,   7'd0};

        hold_exp[0] = '{8'd10, 7'd5, 1'b1, 1'b0};
        hold_exp[1] = '{8'd11, 7'd5, 1'b0, 1'b0};
        hold_exp[2] = '{8'd11, 7'd5, 1'b0, 1'b0};
        hold_exp[3] = '{8'd11, 7'd5, 1'b0, 1'b0};
        hold_exp[4] = '{8'd11, 7'd5, 1'b1, 1'b0};
        hold_exp[5] = '{8'd12, 7'd5, 1'b1, 1'b0};
        hold_exp[6] = '{8'd10, 7'd6, 1'b1, 1'b0};
        hold_exp[7] = '{8'd11, 7'd6, 1'b1, 1'b0};
        hold_exp[8] = '{8'd12, 7'd6, 1'b1, 1'b0};
        hold_exp[9] = '{8'd12, 7'd6, 1'b0, 1'b1};

        bus.start = 1'b0;
        bus.hold  = 1'b0;
        set_req(8'd0, 7'd0, 8'd0, 7'd0, 3'd0);
        step();
        step();
        chk("reset x", int'(bus.x), 0);
        chk("reset y", int'(bus.y), 0);
        chk("reset colour", int'(bus.colour), 0);
        chk("reset plot", int'(bus.plot), 0);
        chk("reset busy", int'(bus.busy), 0);
        chk("reset done", int'(bus.done), 0);
        reset = 1'b0;
        step();

        for (int i = 0; i < 8; i++) begin
            run_vec($sformatf("vec%0d", i), vecs[i]);
            step();
        end

        // Hold for three cycles around pixel (11,5)
        set_req(8'd10, 7'd5, 8'd3, 7'd2, 3'd5);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("hold c%0d x", i), int'(bus.x), int'(hold_exp[i].x));
            chk($sformatf("hold c%0d y", i), int'(bus.y), int'(hold_exp[i].y));
            chk($sformatf("hold c%0d plot", i), int'(bus.plot), int'(hold_exp[i].plot));
            chk($sformatf("hold c%0d done", i), int'(bus.done), int'(hold_exp[i].done));
            if (bus.plot) n++;
            bus.hold = (i <= 2);
            step();
        end
        chk("hold writes", n, 6);
        chk("hold done cleared", int'(bus.done), 0);

        // Second start during FILL and DONE must be ignored
        set_req(8'd10, 7'd5, 8'd3, 7'd2, 3'd5);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        n = 0; dones = 0; badcol = 0;
        for (int i = 0; i < 12; i++) begin
            if (bus.plot) begin
                n++;
                if (bus.colour !== 3'd5) badcol++;
            end
            if (bus.done) dones++;
            if (i == 2) begin
                bus.start = 1'b1;
                set_req(8'd50, 7'd50, 8'd9, 7'd9, 3'd2);
            end
            if (i == 7) bus.start = 1'b0;
            step();
        end
        chk("overlap plots", n, 6);
        chk("overlap dones", dones, 1);
        chk("overlap colour_errs", badcol, 0);
        chk("overlap idle busy", int'(bus.busy), 0);

        // Reset while the third pixel is presented
        set_req(8'd10, 7'd5, 8'd3, 7'd2, 3'd5);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        step();
        step();
        chk("pre-reset x", int'(bus.x), 12);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("abort x", int'(bus.x), 0);
        chk("abort y", int'(bus.y), 0);
        chk("abort plot", int'(bus.plot), 0);
        chk("abort busy", int'(bus.busy), 0);
        dones = 0;
        for (int i = 0; i < 8; i++) begin
            if (bus.done || bus.plot) dones++;
            step();
        end
        chk("abort no activity", dones, 0);

        run_vec("after_reset", vecs[0]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/vga_rect_fill_ctrl.md
Name: vga_rect_fill_ctrl

Overview:
- Sequencer that drives the pixel write port (x, y, colour, plot) of the vga_adapter frame-buffer wrapper.
- On a start request, fills an axis-aligned rectangle with one colour by emitting one pixel write per cycle in raster order.
- Supports hold/back-pressure, clips the rectangle to the screen, and reports busy/done.
- Sits between draw logic (top-level FSM or switches/keys) and the adapter; replaces free-running x/y counters.

Parameters:
- SCREEN_W, 160, horizontal resolution in pixels; x coordinates 0..SCREEN_W-1.
- SCREEN_H, 120, vertical resolution in pixels; y coordinates 0..SCREEN_H-1.
- COLOUR_BITS, 3, width of the colour field.

Ports:
- clock  input  1  system clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  fill request; sampled only in IDLE.
- x0  input  8  rectangle left column.
- y0  input  7  rectangle top row.
- w  input  8  rectangle width in pixels.
- h  input  7  rectangle height in pixels.
- colour_in  input  COLOUR_BITS  fill colour.
- hold  input  1  stall; freezes the pixel walk while high.
- x  output  8  pixel column to the adapter.
- y  output  7  pixel row to the adapter.
- colour  output  COLOUR_BITS  pixel colour to the adapter.
- plot  output  1  pixel write enable to the adapter.
- busy  output  1  high from acceptance through the last pixel.
- done  output  1  one-cycle completion pulse.

Behaviour:
- Reset: state=IDLE; x=0, y=0, colour=0, plot=0, busy=0, done=0. Reset overrides everything, including an in-progress fill; the aborted fill produces no done pulse.
- All outputs are registered. x, y, colour and plot are coherent in the same cycle, and the adapter writes whenever plot=1.
- States: IDLE, FILL, DONE.
- IDLE with start=1:
  - Latch x0, y0 and colour_in.
  - Compute x_end = min(x0+w-1, SCREEN_W-1) and y_end = min(y0+h-1, SCREEN_H-1). Use 9-bit arithmetic for x and 8-bit for y, so there is no wrap.
  - Degenerate request (w==0, h==0, x0>=SCREEN_W or y0>=SCREEN_H): go to DONE with no plot.
  - Otherwise: go to FILL, set busy=1, and present the first pixel (x0, y0) with plot=1 in the next cycle. Latency from start to first plot is 1 cycle.
- FILL:
  - Each cycle with hold=0, the presented pixel is written.
  - Advance: if x<x_end then x+1; else x=x0 and y+1.
  - When x==x_end and y==y_end, the pixel is written and the next state is DONE with plot=0.
  - hold=1 in FILL: plot=0 that cycle, and x/y/state are frozen. On resuming, the same pixel is re-presented with plot=1, so no pixel is skipped or duplicated.
- DONE: done=1 and busy=0 for exactly one cycle, plot=0, then IDLE. start is ignored in DONE.
- start during FILL or DONE is ignored; it is not queued.
- colour is constant for the whole fill, because it is latched at acceptance; input changes after acceptance have no effect.
- Input changes to x0/y0/w/h after acceptance have no effect.
- Without hold, the number of plot cycles is (x_end-x0+1)*(y_end-y0+1).
- In IDLE, x/y keep their last values and plot=0.

Test Plan:
- Small rect: x0=10, y0=5, w=3, h=2, colour_in=5, start for 1 cycle -> next cycle plot=1 and the exact sequence (10,5) (11,5) (12,5) (10,6) (11,6) (12,6) with colour=5 on 6 consecutive cycles. Then plot=0, done=1 for 1 cycle, busy low.
- Full screen: x0=0, y0=0, w=160, h=120 -> 19200 plot cycles, last pixel (159,119), done the cycle after, never x>159 or y>119.
- Clipping: x0=158, y0=119, w=5, h=4 -> only (158,119) and (159,119) plotted, then done.
- Degenerate: w=0 (and separately x0=200) with start -> plot never asserts, busy stays 0, done pulses once.
- Hold: small rect with hold=1 for 3 cycles while (11,5) is presented -> plot=0 for those 3 cycles, then (11,5) is re-presented with plot=1 and the sequence is otherwise unchanged (6 writes total).
- Reset/overlap:
  - start asserted again mid-fill -> ignored; pixel count unchanged.
  - reset at pixel 3 -> next cycle x=0, y=0, plot=0, busy=0, no done.
  - A new start afterwards fills normally.
